// File: rtl/gray_to_bin.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gray_to_bin : registered Gray-code to binary converter, one word per clk.  |
// | Optional macro GRAY_TO_BIN_PIPE_EN splits the XOR chain over two stages.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module gray_to_bin #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] gray_in,
  input  logic                  gray_valid,
  output logic [DATA_WIDTH-1:0] binary_out,
  output logic                  binary_valid
);

  logic [DATA_WIDTH-1:0] r_bin;
  logic                  r_valid;

`ifdef GRAY_TO_BIN_PIPE_EN
  localparam int c_HI_W = (DATA_WIDTH + 1) / 2;
  localparam int c_LO_W = DATA_WIDTH - c_HI_W;

  logic [DATA_WIDTH-1:c_LO_W] w_hi;
  logic [DATA_WIDTH-1:c_LO_W] r_s1_hi;
  logic                       r_s1_valid;

  // Upper half is fully converted in stage 1; b[c_LO_W] then seeds the lower half.
  always_comb begin : comb_hi
    logic w_acc;
    w_acc = 1'b0;
    w_hi  = '0;
    for (int i = DATA_WIDTH - 1; i >= c_LO_W; i--) begin
      w_acc   = w_acc ^ gray_in[i];
      w_hi[i] = w_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_hi    <= '0;
    end else begin
      r_s1_valid <= gray_valid;
      if (gray_valid) begin
        r_s1_hi <= w_hi;
      end
    end
  end

  generate
    if (c_LO_W > 0) begin : g_lo
      logic [c_LO_W-1:0] w_pre;
      logic [c_LO_W-1:0] r_s1_lo;

      always_comb begin : comb_pre
        logic w_acc;
        w_acc = 1'b0;
        w_pre = '0;
        for (int i = c_LO_W - 1; i >= 0; i--) begin
          w_acc    = w_acc ^ gray_in[i];
          w_pre[i] = w_acc;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_s1_lo <= '0;
        end else if (gray_valid) begin
          r_s1_lo <= w_pre;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_bin <= '0;
        end else if (r_s1_valid) begin
          r_bin <= {r_s1_hi, r_s1_lo ^ {c_LO_W{r_s1_hi[c_LO_W]}}};
        end
      end
    end else begin : g_no_lo
      always_ff @(posedge clk) begin
        if (rst) begin
          r_bin <= '0;
        end else if (r_s1_valid) begin
          r_bin <= r_s1_hi;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_s1_valid;
    end
  end
`else
  logic [DATA_WIDTH-1:0] w_bin;

  always_comb begin : comb_bin
    logic w_acc;
    w_acc = 1'b0;
    w_bin = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      w_acc    = w_acc ^ gray_in[i];
      w_bin[i] = w_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= gray_valid;
      if (gray_valid) begin
        r_bin <= w_bin;
      end
    end
  end
`endif

  assign binary_out   = r_bin;
  assign binary_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_gray_to_bin.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gray_to_bin : scoreboard bench for gray_to_bin at widths 8, 5 and 1.    |
// | Revision       : 1.0  initial release                                      |
// +----------------------------------------------------------------------------+
module tb_gray_to_bin;

`ifdef GRAY_TO_BIN_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [7:0] b8;
    logic [4:0] b5;
    logic       b1;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       gray_valid = 1'b0;
  logic [7:0] gray_in = 8'h00;
  logic [7:0] out8;
  logic [4:0] out5;
  logic [0:0] out1;
  logic       val8, val5, val1;

  int   cyc = 0;
  logic rst_q = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];
  logic [7:0] model8 = '0;
  logic [4:0] model5 = '0;
  logic       model1 = 1'b0;

  gray_to_bin #(.DATA_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .gray_in(gray_in), .gray_valid(gray_valid),
    .binary_out(out8), .binary_valid(val8));
  gray_to_bin #(.DATA_WIDTH(5)) u_dut5 (
    .clk(clk), .rst(rst), .gray_in(gray_in[4:0]), .gray_valid(gray_valid),
    .binary_out(out5), .binary_valid(val5));
  gray_to_bin #(.DATA_WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .gray_in(gray_in[0:0]), .gray_valid(gray_valid),
    .binary_out(out1), .binary_valid(val1));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference via XOR of right shifts, b = g ^ g>>1 ^ g>>2 ^ ...
  function automatic logic [4:0] g2b5(input logic [4:0] g);
    logic [4:0] b;
    b = g;
    for (int s = 1; s < 5; s++) b = b ^ (g >> s);
    return b;
  endfunction

  // Inputs change 1 time unit after the edge; edge M = cyc+1 samples them.
  task automatic drive(input logic r, input logic v, input logic [7:0] g, input logic [7:0] e8);
    exp_t e;
    int   m;
    m          = cyc + 1;
    rst        = r;
    gray_valid = v;
    gray_in    = g;
    if (r) begin
      for (int k = q.size() - 1; k >= 0; k--)
        if (q[k].due >= m) q.delete(k);
    end else if (v) begin
      e.b8  = e8;
      e.b5  = g2b5(g[4:0]);
      e.b1  = g[0];
      e.due = m + LAT - 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      check_eq("valid5_eq", {31'd0, val5}, {31'd0, val8});
      check_eq("valid1_eq", {31'd0, val1}, {31'd0, val8});
      if (rst_q) begin
        check_eq("rst_valid", {31'd0, val8}, 32'd0);
        check_eq("rst_out8", {24'd0, out8}, 32'd0);
        check_eq("rst_out5", {27'd0, out5}, 32'd0);
        check_eq("rst_out1", {31'd0, out1}, 32'd0);
        model8 = '0;
        model5 = '0;
        model1 = 1'b0;
      end else if (val8) begin
        if (q.size() == 0) begin
          check_eq("spurious_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check_eq("out8", {24'd0, out8}, {24'd0, e.b8});
          check_eq("out5", {27'd0, out5}, {27'd0, e.b5});
          check_eq("out1", {31'd0, out1}, {31'd0, e.b1});
          check_eq("latency", cyc, e.due);
          model8 = e.b8;
          model5 = e.b5;
          model1 = e.b1;
        end
      end else begin
        check_eq("hold8", {24'd0, out8}, {24'd0, model8});
        check_eq("hold5", {27'd0, out5}, {27'd0, model5});
        check_eq("hold1", {31'd0, out1}, {31'd0, model1});
        if (q.size() > 0 && q[0].due <= cyc) begin
          check_eq("missing_valid", 32'd0, 32'd1);
          void'(q.pop_front());
        end
      end
    end
  end

  logic [7:0] dir_g [5] = '{8'b01010101, 8'b01010111, 8'b01010011, 8'b01011011, 8'b01110011};
  logic [7:0] dir_b [5] = '{8'b01100110, 8'b01100101, 8'b01100010, 8'b01101101, 8'b01011101};

  initial begin
    // Reset held with live-looking input that must be ignored.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 8'hFF, 8'h00);
    drive(1'b0, 1'b0, 8'hFF, 8'h00);
    drive(1'b0, 1'b0, 8'h00, 8'h00);

    foreach (dir_g[i]) begin
      drive(1'b0, 1'b1, dir_g[i], dir_b[i]);
      repeat (LAT + 1) drive(1'b0, 1'b0, 8'(~dir_g[i]), 8'h00);
    end

    for (int n = 0; n < 256; n++) begin
      logic [7:0] nb;
      nb = 8'(n);
      drive(1'b0, 1'b1, nb ^ (nb >> 1), nb);
    end
    repeat (LAT + 1) drive(1'b0, 1'b0, 8'($urandom), 8'h00);

    drive(1'b0, 1'b1, 8'h80, 8'hFF);
    drive(1'b0, 1'b0, 8'($urandom), 8'h00);
    drive(1'b0, 1'b1, 8'hC0, 8'h80);
    repeat (LAT + 2) drive(1'b0, 1'b0, 8'($urandom), 8'h00);

    // Width corner: all-ones gives 8'hAA / 5'b10101 / 1.
    drive(1'b0, 1'b1, 8'hFF, 8'hAA);
    repeat (LAT + 1) drive(1'b0, 1'b0, 8'h00, 8'h00);

    drive(1'b0, 1'b1, 8'h01, 8'h01);
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b1, 8'h03, 8'h02);
    repeat (LAT + 2) drive(1'b0, 1'b0, 8'h00, 8'h00);

    check_eq("drain", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
